m1_wsched: RTL and testbench



---
 rtl/m1_sha_pkg.sv | 23 ++
 rtl/m1_kconst.sv | 80 ++++++++
 rtl/m1_wsched.sv | 98 +++++++++
 tb/tb_m1_wsched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m1_sha_pkg.sv
// Shared SHA-256 schedule definitions: widths, round count, the small sigma
// functions and the scheduler state encoding.
package m1_sha_pkg;

    localparam int WORD_W     = 32;
    localparam int BLK_W      = 512;
    localparam int ROUNDS_MAX = 64;
    localparam int WIN_N      = BLK_W / WORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/m1_kconst.sv
// SHA-256 round-constant ROM: 6-bit round index to 32-bit K[t], pure decode.
module m1_kconst
    import m1_sha_pkg::*;
(
    input  logic [5:0]        idx_i,
    output logic [WORD_W-1:0] k_o
);

    always_comb begin
        k_o = '0;
        case (idx_i)
            6'd0:  k_o = 32'h428a2f98;
            6'd1:  k_o = 32'h71374491;
            6'd2:  k_o = 32'hb5c0fbcf;
            6'd3:  k_o = 32'he9b5dba5;
            6'd4:  k_o = 32'h3956c25b;
            6'd5:  k_o = 32'h59f111f1;
            6'd6:  k_o = 32'h923f82a4;
            6'd7:  k_o = 32'hab1c5ed5;
            6'd8:  k_o = 32'hd807aa98;
            6'd9:  k_o = 32'h12835b01;
            6'd10: k_o = 32'h243185be;
            6'd11: k_o = 32'h550c7dc3;
            6'd12: k_o = 32'h72be5d74;
            6'd13: k_o = 32'h80deb1fe;
            6'd14: k_o = 32'h9bdc06a7;
            6'd15: k_o = 32'hc19bf174;
            6'd16: k_o = 32'he49b69c1;
            6'd17: k_o = 32'hefbe4786;
            6'd18: k_o = 32'h0fc19dc6;
            6'd19: k_o = 32'h240ca1cc;
            6'd20: k_o = 32'h2de92c6f;
            6'd21: k_o = 32'h4a7484aa;
            6'd22: k_o = 32'h5cb0a9dc;
            6'd23: k_o = 32'h76f988da;
            6'd24: k_o = 32'h983e5152;
            6'd25: k_o = 32'ha831c66d;
            6'd26: k_o = 32'hb00327c8;
            6'd27: k_o = 32'hbf597fc7;
            6'd28: k_o = 32'hc6e00bf3;
            6'd29: k_o = 32'hd5a79147;
            6'd30: k_o = 32'h06ca6351;
            6'd31: k_o = 32'h14292967;
            6'd32: k_o = 32'h27b70a85;
            6'd33: k_o = 32'h2e1b2138;
            6'd34: k_o = 32'h4d2c6dfc;
            6'd35: k_o = 32'h53380d13;
            6'd36: k_o = 32'h650a7354;
            6'd37: k_o = 32'h766a0abb;
            6'd38: k_o = 32'h81c2c92e;
            6'd39: k_o = 32'h92722c85;
            6'd40: k_o = 32'ha2bfe8a1;
            6'd41: k_o = 32'ha81a664b;
            6'd42: k_o = 32'hc24b8b70;
            6'd43: k_o = 32'hc76c51a3;
            6'd44: k_o = 32'hd192e819;
            6'd45: k_o = 32'hd6990624;
            6'd46: k_o = 32'hf40e3585;
            6'd47: k_o = 32'h106aa070;
            6'd48: k_o = 32'h19a4c116;
            6'd49: k_o = 32'h1e376c08;
            6'd50: k_o = 32'h2748774c;
            6'd51: k_o = 32'h34b0bcb5;
            6'd52: k_o = 32'h391c0cb3;
            6'd53: k_o = 32'h4ed8aa4a;
            6'd54: k_o = 32'h5b9cca4f;
            6'd55: k_o = 32'h682e6ff3;
            6'd56: k_o = 32'h748f82ee;
            6'd57: k_o = 32'h78a5636f;
            6'd58: k_o = 32'h84c87814;
            6'd59: k_o = 32'h8cc70208;
            6'd60: k_o = 32'h90befffa;
            6'd61: k_o = 32'ha4506ceb;
            6'd62: k_o = 32'hbef9a3f7;
            6'd63: k_o = 32'hc67178f2;
            default: k_o = '0;
        endcase
    end

endmodule

// File: rtl/m1_wsched.sv
// SHA-256 message schedule: captures a 512-bit block and streams W[t]/K[t]
// one round per accepted beat, extending W in a 16-word sliding window.
module m1_wsched
    import m1_sha_pkg::*;
#(
    parameter int NROUNDS = ROUNDS_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [BLK_W-1:0]  blk_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic [WORD_W-1:0] wt_out,
    output logic [WORD_W-1:0] k_out,
    output logic [5:0]        rnd_idx,
    output logic              done
);

    localparam logic [5:0] LAST = 6'(NROUNDS - 1);

    state_e                        state_q, state_d;
    logic [WIN_N-1:0][WORD_W-1:0]  w_q, w_d;
    logic [5:0]                    cnt_q, cnt_d;
    logic                          done_q, done_d;
    logic                          accept;
    logic [WORD_W-1:0]             w_new;

    assign accept = (state_q == RUN) && rnd_ready;

    // w[0] is W[t]; the new tail word is W[t+16].
    assign w_new = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < WIN_N; i++)
                            w_d[i] = blk_data[BLK_W-1-WORD_W*i -: WORD_W];
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (cnt_q == LAST) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            for (int i = 0; i < WIN_N-1; i++)
                                w_d[i] = w_q[i+1];
                            w_d[WIN_N-1] = w_new;
                            cnt_d        = cnt_q + 6'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign blk_ready = (state_q == IDLE);
    assign rnd_valid = (state_q == RUN);
    assign wt_out    = w_q[0];
    assign rnd_idx   = cnt_q;
    assign done      = done_q;

    m1_kconst u_kconst (
        .idx_i (cnt_q),
        .k_o   (k_out)
    );

endmodule

// File: tb/tb_m1_wsched.sv
// Directed and random checks of m1_wsched against a plain SHA-256 schedule model.
module tb_m1_wsched;

    logic         clk, rst_n, abort, blk_valid, rnd_ready;
    logic [511:0] blk_data;
    logic         blk_ready, rnd_valid, done;
    logic [31:0]  wt_out, k_out;
    logic [5:0]   rnd_idx;

    int nvec = 0;
    int nmis = 0;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];

    m1_wsched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .wt_out    (wt_out),
        .k_out     (k_out),
        .rnd_idx   (rnd_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [511:0] b);
        chk("ld_ready", 32'(blk_ready), 32'd1);
        blk_valid = 1'b1;
        blk_data  = b;
        step();
        blk_valid = 1'b0;
    endtask

    // Called one cycle after the capture edge; streams all rounds of exp_w.
    // kill_at >= 0 ends the block at that round by abort (kill_rst=0) or reset.
    task automatic run_rounds(input int stall_at, input int stall_n, input int pct,
                              input int kill_at, input bit kill_rst,
                              input bit bv_hold, input logic [511:0] bv_data);
        int t = 0;
        int cyc = 0;
        int nstall = 0;
        bit rdy;
        blk_valid = bv_hold;
        blk_data  = bv_data;
        while (t < 64) begin
            if (cyc > 2000) begin
                chk("timeout", 32'(t), 32'd64);
                return;
            end
            chk("rvalid", 32'(rnd_valid), 32'd1);
            chk("idx", 32'(rnd_idx), 32'(t));
            chk("wt", wt_out, exp_w[t]);
            chk("k", k_out, KT[t]);
            chk("done_run", 32'(done), 32'd0);
            chk("bready_run", 32'(blk_ready), 32'd0);
            obs_w[t] = wt_out;
            obs_k[t] = k_out;
            if (t == kill_at) begin
                if (kill_rst) begin
                    #1 rst_n = 1'b0;
                    #1;
                    chk("rst_rvalid", 32'(rnd_valid), 32'd0);
                    chk("rst_bready", 32'(blk_ready), 32'd1);
                    chk("rst_wt", wt_out, 32'd0);
                    chk("rst_idx", 32'(rnd_idx), 32'd0);
                    chk("rst_k", k_out, 32'h428a2f98);
                    chk("rst_done", 32'(done), 32'd0);
                    #2 rst_n = 1'b1;
                    rnd_ready = 1'b0;
                    step();
                end else begin
                    abort     = 1'b1;
                    rnd_ready = 1'b1;
                    step();
                    abort     = 1'b0;
                    rnd_ready = 1'b0;
                    chk("abt_rvalid", 32'(rnd_valid), 32'd0);
                    chk("abt_bready", 32'(blk_ready), 32'd1);
                    chk("abt_done", 32'(done), 32'd0);
                    step();
                    chk("abt_done2", 32'(done), 32'd0);
                end
                return;
            end
            if (t == stall_at && nstall < stall_n) begin
                rdy = 1'b0;
                nstall++;
            end else begin
                rdy = !(pct > 0 && $urandom_range(0, 99) < pct);
            end
            rnd_ready = rdy;
            step();
            if (rdy) t++;
            cyc++;
        end
        rnd_ready = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("end_rvalid", 32'(rnd_valid), 32'd0);
        chk("end_bready", 32'(blk_ready), 32'd1);
        step();
        chk("done_once", 32'(done), 32'd0);
    endtask

    initial begin
        logic [511:0] abc, blk_a, blk_b, blk_r;
        rst_n     = 1'b0;
        abort     = 1'b0;
        blk_valid = 1'b0;
        rnd_ready = 1'b0;
        blk_data  = '0;
        abc       = {32'h61626380, 448'd0, 32'h00000018};

        #2;
        chk("rs_bready", 32'(blk_ready), 32'd1);
        chk("rs_rvalid", 32'(rnd_valid), 32'd0);
        chk("rs_wt", wt_out, 32'd0);
        chk("rs_idx", 32'(rnd_idx), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_k", k_out, 32'h428a2f98);
        #20 rst_n = 1'b1;
        step();

        // padded "abc", no stalls
        build(abc);
        load(abc);
        run_rounds(-1, 0, 0, -1, 1'b0, 1'b0, '0);
        chk("abc_w0", obs_w[0], 32'h61626380);
        chk("abc_w16", obs_w[16], 32'h61626380);
        chk("abc_w17", obs_w[17], 32'h000f0000);
        chk("abc_k0", obs_k[0], 32'h428a2f98);
        chk("abc_k16", obs_k[16], 32'he49b69c1);
        chk("abc_k63", obs_k[63], 32'hc67178f2);

        // five-cycle stall at round 20
        load(abc);
        run_rounds(20, 5, 0, -1, 1'b0, 1'b0, '0);

        // back-to-back: B held on the bus throughout A, taken after A's done
        for (int i = 0; i < 16; i++) begin
            blk_a[511-32*i -: 32] = 32'h01010101 * (i + 1);
            blk_b[511-32*i -: 32] = 32'hdeadbeef ^ (32'h00100001 * i);
        end
        build(blk_a);
        load(blk_a);
        run_rounds(-1, 0, 0, -1, 1'b0, 1'b1, blk_b);
        blk_valid = 1'b0;
        build(blk_b);
        run_rounds(-1, 0, 0, -1, 1'b0, 1'b0, '0);

        // abort beats blk_valid in IDLE
        abort     = 1'b1;
        blk_valid = 1'b1;
        blk_data  = blk_a;
        step();
        abort     = 1'b0;
        blk_valid = 1'b0;
        chk("abt_idle_rvalid", 32'(rnd_valid), 32'd0);
        chk("abt_idle_bready", 32'(blk_ready), 32'd1);

        // abort at round 30, then a fresh block
        build(abc);
        load(abc);
        run_rounds(-1, 0, 0, 30, 1'b0, 1'b0, '0);
        build(blk_b);
        load(blk_b);
        run_rounds(-1, 0, 0, -1, 1'b0, 1'b0, '0);

        // async reset at round 40, then normal operation
        build(blk_a);
        load(blk_a);
        run_rounds(-1, 0, 0, 40, 1'b1, 1'b0, '0);
        build(abc);
        load(abc);
        run_rounds(-1, 0, 0, -1, 1'b0, 1'b0, '0);

        // random blocks with random stalls and idle gaps
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 16; i++) blk_r[511-32*i -: 32] = $urandom();
            build(blk_r);
            load(blk_r);
            run_rounds(-1, 0, 30, -1, 1'b0, 1'b0, '0);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
